// File: rtl/time_set_input_if.sv
// time_set_input_if
//   Groups the button, current-time and edit/load signals exchanged between the
//   time-setting front end and the rest of the clock.
//   master : drives raw buttons and cur_* digits, observes edit/load/blank.
//   slave  : the time_set_input block itself.
interface time_set_input_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_ctr;
  logic       btn_left;
  logic       btn_right;
  logic [3:0] cur_min_ones;
  logic [3:0] cur_min_tens;
  logic [3:0] cur_hour_ones;
  logic [3:0] cur_hour_tens;
  logic       editing;
  logic       edit_field;
  logic       load;
  logic [3:0] load_min_ones;
  logic [3:0] load_min_tens;
  logic [3:0] load_hour_ones;
  logic [3:0] load_hour_tens;
  logic [3:0] blank;

  modport master (
    output btn_up, btn_down, btn_ctr, btn_left, btn_right,
    output cur_min_ones, cur_min_tens, cur_hour_ones, cur_hour_tens,
    input  editing, edit_field, load,
    input  load_min_ones, load_min_tens, load_hour_ones, load_hour_tens,
    input  blank
  );

  modport slave (
    input  btn_up, btn_down, btn_ctr, btn_left, btn_right,
    input  cur_min_ones, cur_min_tens, cur_hour_ones, cur_hour_tens,
    output editing, edit_field, load,
    output load_min_ones, load_min_tens, load_hour_ones, load_hour_tens,
    output blank
  );
endinterface

// File: rtl/time_set_input.sv
// time_set_input
//   Push-button front end for the 24-hour clock. Synchronises and debounces the
//   five buttons, auto-repeats up/down, runs the edit FSM (RUN, EDIT_H, EDIT_M,
//   COMMIT) and emits a one-cycle BCD load plus a blink mask for the display.
// Ports:
//   clk       : system clock
//   btn_reset : asynchronous active-low reset
//   bus       : time_set_input_if.slave (buttons, cur_* in; editing,
//               edit_field, load, load_* digits, blank out)
module time_set_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic            clk,
  input  logic            btn_reset,
  time_set_input_if.slave bus
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W  = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_DELAY   = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0]  HOLD_PERIOD  = HOLD_W'(REPEAT_PERIOD);
  localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_CYCLES - 1);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] EDIT_H = 2'd1;
  localparam logic [1:0] EDIT_M = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  // Button order: 0 up, 1 down, 2 ctr, 3 left, 4 right.
  logic [4:0]       w_raw;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_stable;
  logic [4:0]       r_stableD;
  logic [DEB_W-1:0] r_debCnt [5];
  logic [4:0]       w_press;

  assign w_raw   = {bus.btn_right, bus.btn_left, bus.btn_ctr, bus.btn_down, bus.btn_up};
  assign w_press = r_stable & ~r_stableD;

  // Synchroniser plus debounce: stable only flips once sync has disagreed with
  // it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_stableD <= '0;
      for (int i = 0; i < 5; i++) r_debCnt[i] <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_stableD <= r_stable;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + 1'b1;
        end
      end
    end
  end

  // Hold counters for up/down. The counter is 0 on the press cycle; the first
  // repeat fires at REPEAT_DELAY, then the counter restarts at 1 so each later
  // repeat lands exactly REPEAT_PERIOD cycles after the previous one.
  logic [HOLD_W-1:0] r_holdCnt [2];
  logic [1:0]        r_rep;
  logic [1:0]        w_repFire;

  always_comb begin
    w_repFire = '0;
    for (int i = 0; i < 2; i++)
      w_repFire[i] = r_stable[i] && (r_holdCnt[i] == (r_rep[i] ? HOLD_PERIOD : HOLD_DELAY));
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_holdCnt[0] <= '0;
      r_holdCnt[1] <= '0;
      r_rep        <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_stable[i]) begin
          r_holdCnt[i] <= '0;
          r_rep[i]     <= 1'b0;
        end else if (w_repFire[i]) begin
          r_holdCnt[i] <= HOLD_W'(1);
          r_rep[i]     <= 1'b1;
        end else begin
          r_holdCnt[i] <= r_holdCnt[i] + 1'b1;
        end
      end
    end
  end

  logic w_evUp, w_evDown, w_evCtr, w_evToggle;
  assign w_evUp     = w_press[0] | w_repFire[0];
  assign w_evDown   = w_press[1] | w_repFire[1];
  assign w_evCtr    = w_press[2];
  assign w_evToggle = w_press[3] | w_press[4];

  logic [1:0] r_state;
  logic [3:0] r_hourTens, r_hourOnes, r_minTens, r_minOnes;
  logic       w_editing, w_doCapture, w_doCommit, w_doToggle, w_doAdjust;
  logic       w_hourValid, w_minValid;

  // One action per cycle: ctr beats left/right, which beat up/down; up and down
  // together cancel.
  assign w_editing   = (r_state == EDIT_H) || (r_state == EDIT_M);
  assign w_doCapture = (r_state == RUN) && w_evCtr;
  assign w_doCommit  = w_editing && w_evCtr;
  assign w_doToggle  = w_editing && !w_evCtr && w_evToggle;
  assign w_doAdjust  = w_editing && !w_evCtr && !w_evToggle && (w_evUp ^ w_evDown);

  assign w_hourValid = ((bus.cur_hour_tens < 4'd2) && (bus.cur_hour_ones <= 4'd9)) ||
                       ((bus.cur_hour_tens == 4'd2) && (bus.cur_hour_ones <= 4'd3));
  assign w_minValid  = (bus.cur_min_tens <= 4'd5) && (bus.cur_min_ones <= 4'd9);

  function automatic logic [7:0] stepHour(input logic [7:0] h, input logic up);
    logic [7:0] v;
    if (up) begin
      if (h == 8'h23)             v = 8'h00;
      else if (h[3:0] == 4'd9)    v = {h[7:4] + 4'd1, 4'd0};
      else                        v = {h[7:4], h[3:0] + 4'd1};
    end else begin
      if (h == 8'h00)             v = 8'h23;
      else if (h[3:0] == 4'd0)    v = {h[7:4] - 4'd1, 4'd9};
      else                        v = {h[7:4], h[3:0] - 4'd1};
    end
    return v;
  endfunction

  function automatic logic [7:0] stepMin(input logic [7:0] m, input logic up);
    logic [7:0] v;
    if (up) begin
      if (m[3:0] == 4'd9)         v = {((m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1), 4'd0};
      else                        v = {m[7:4], m[3:0] + 4'd1};
    end else begin
      if (m[3:0] == 4'd0)         v = {((m[7:4] == 4'd0) ? 4'd5 : m[7:4] - 4'd1), 4'd9};
      else                        v = {m[7:4], m[3:0] - 4'd1};
    end
    return v;
  endfunction

  // Edit FSM and edit registers. Invalid captured fields fall back to 00.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_state    <= RUN;
      r_hourTens <= '0;
      r_hourOnes <= '0;
      r_minTens  <= '0;
      r_minOnes  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_doCapture) begin
            r_state    <= EDIT_H;
            r_hourTens <= w_hourValid ? bus.cur_hour_tens : 4'd0;
            r_hourOnes <= w_hourValid ? bus.cur_hour_ones : 4'd0;
            r_minTens  <= w_minValid  ? bus.cur_min_tens  : 4'd0;
            r_minOnes  <= w_minValid  ? bus.cur_min_ones  : 4'd0;
          end
        end
        EDIT_H, EDIT_M: begin
          if (w_doCommit) begin
            r_state <= COMMIT;
          end else if (w_doToggle) begin
            r_state <= (r_state == EDIT_H) ? EDIT_M : EDIT_H;
          end else if (w_doAdjust) begin
            if (r_state == EDIT_H)
              {r_hourTens, r_hourOnes} <= stepHour({r_hourTens, r_hourOnes}, w_evUp);
            else
              {r_minTens, r_minOnes} <= stepMin({r_minTens, r_minOnes}, w_evUp);
          end
        end
        COMMIT: r_state <= RUN;
      endcase
    end
  end

  // Blink phase restarts visible whenever a field is entered or adjusted, so
  // the user always sees the new value immediately.
  logic               r_phase;
  logic [BLINK_W-1:0] r_blinkCnt;
  logic               w_blinkForce;
  assign w_blinkForce = w_doCapture || w_doToggle || w_doAdjust;

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      r_phase    <= 1'b0;
      r_blinkCnt <= '0;
    end else if (w_blinkForce) begin
      r_phase    <= 1'b0;
      r_blinkCnt <= '0;
    end else if (r_blinkCnt == BLINK_LAST) begin
      r_phase    <= ~r_phase;
      r_blinkCnt <= '0;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  assign bus.editing        = w_editing;
  assign bus.edit_field     = (r_state == EDIT_M);
  assign bus.load           = (r_state == COMMIT);
  assign bus.load_hour_tens = r_hourTens;
  assign bus.load_hour_ones = r_hourOnes;
  assign bus.load_min_tens  = r_minTens;
  assign bus.load_min_ones  = r_minOnes;
  assign bus.blank          = ((r_state == EDIT_H) && r_phase) ? 4'b1100 :
                              ((r_state == EDIT_M) && r_phase) ? 4'b0011 : 4'b0000;

endmodule

// File: tb/tb_time_set_input.sv
// tb_time_set_input
//   Directed bench for time_set_input with short debounce/repeat/blink timing.
//   A table of button steps covers the edit flow and BCD wrap cases; hand
//   sequences cover bounce, auto-repeat, simultaneous buttons, blink and reset.
`timescale 1ns/1ps
module tb_time_set_input;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_CTR   = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;

  logic clk;
  logic btnReset;
  int   checks;
  int   errors;
  int   loadPulses;

  time_set_input_if bus ();

  time_set_input #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .BLINK_CYCLES   (8)
  ) dut (
    .clk      (clk),
    .btn_reset(btnReset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the load pulse is seen high.
  always @(negedge clk) if (bus.load === 1'b1) loadPulses++;

  typedef struct {
    int          btn;
    logic [15:0] cur;
    logic        expEditing;
    logic        expField;
    logic [15:0] expDigits;
  } stepT;

  stepT steps [22];

  function automatic logic [15:0] loadDigits();
    return {bus.load_hour_tens, bus.load_hour_ones, bus.load_min_tens, bus.load_min_ones};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic setButton(input int idx, input logic v);
    case (idx)
      BTN_UP:    bus.btn_up    = v;
      BTN_DOWN:  bus.btn_down  = v;
      BTN_CTR:   bus.btn_ctr   = v;
      BTN_LEFT:  bus.btn_left  = v;
      default:   bus.btn_right = v;
    endcase
  endtask

  task automatic setCur(input logic [15:0] v);
    bus.cur_hour_tens = v[15:12];
    bus.cur_hour_ones = v[11:8];
    bus.cur_min_tens  = v[7:4];
    bus.cur_min_ones  = v[3:0];
  endtask

  // Clean press: held long enough to debounce, released long before a repeat.
  task automatic applyStimulus(input int idx);
    @(negedge clk);
    setButton(idx, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    setButton(idx, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " editing"}, 32'(bus.editing), 32'd0);
    checkOutput({tag, " edit_field"}, 32'(bus.edit_field), 32'd0);
    checkOutput({tag, " load"}, 32'(bus.load), 32'd0);
    checkOutput({tag, " digits"}, 32'(loadDigits()), 32'h0000);
    checkOutput({tag, " blank"}, 32'(bus.blank), 32'd0);
  endtask

  initial begin
    int   savedLoads;
    logic [3:0] expBlank;

    checks     = 0;
    errors     = 0;
    loadPulses = 0;
    btnReset   = 1'b1;
    setButton(BTN_UP, 1'b0);
    setButton(BTN_DOWN, 1'b0);
    setButton(BTN_CTR, 1'b0);
    setButton(BTN_LEFT, 1'b0);
    setButton(BTN_RIGHT, 1'b0);
    setCur(16'h0000);

    // Edit flow table: button, cur time, then expected editing/field/digits.
    steps[0]  = '{BTN_CTR,   16'h2359, 1'b1, 1'b0, 16'h2359};
    steps[1]  = '{BTN_UP,    16'h2359, 1'b1, 1'b0, 16'h0059};
    steps[2]  = '{BTN_RIGHT, 16'h2359, 1'b1, 1'b1, 16'h0059};
    steps[3]  = '{BTN_UP,    16'h2359, 1'b1, 1'b1, 16'h0000};
    steps[4]  = '{BTN_CTR,   16'h2359, 1'b0, 1'b0, 16'h0000};
    steps[5]  = '{BTN_UP,    16'h0000, 1'b0, 1'b0, 16'h0000};
    steps[6]  = '{BTN_CTR,   16'h0000, 1'b1, 1'b0, 16'h0000};
    steps[7]  = '{BTN_DOWN,  16'h0000, 1'b1, 1'b0, 16'h2300};
    steps[8]  = '{BTN_RIGHT, 16'h0000, 1'b1, 1'b1, 16'h2300};
    steps[9]  = '{BTN_DOWN,  16'h0000, 1'b1, 1'b1, 16'h2359};
    steps[10] = '{BTN_LEFT,  16'h0000, 1'b1, 1'b0, 16'h2359};
    steps[11] = '{BTN_CTR,   16'h0000, 1'b0, 1'b0, 16'h2359};
    steps[12] = '{BTN_CTR,   16'h0939, 1'b1, 1'b0, 16'h0939};
    steps[13] = '{BTN_UP,    16'h0939, 1'b1, 1'b0, 16'h1039};
    steps[14] = '{BTN_RIGHT, 16'h0939, 1'b1, 1'b1, 16'h1039};
    steps[15] = '{BTN_UP,    16'h0939, 1'b1, 1'b1, 16'h1040};
    steps[16] = '{BTN_CTR,   16'h0939, 1'b0, 1'b0, 16'h1040};
    steps[17] = '{BTN_CTR,   16'h2000, 1'b1, 1'b0, 16'h2000};
    steps[18] = '{BTN_DOWN,  16'h2000, 1'b1, 1'b0, 16'h1900};
    steps[19] = '{BTN_CTR,   16'h2000, 1'b0, 1'b0, 16'h1900};
    steps[20] = '{BTN_CTR,   16'h2459, 1'b1, 1'b0, 16'h0059};
    steps[21] = '{BTN_CTR,   16'h2459, 1'b0, 1'b0, 16'h0059};

    // Reset state.
    #3 btnReset = 1'b0;
    #4 checkAllZero("reset");
    repeat (2) @(negedge clk);
    btnReset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      setCur(steps[i].cur);
      applyStimulus(steps[i].btn);
      checkOutput($sformatf("step%0d editing", i), 32'(bus.editing), 32'(steps[i].expEditing));
      checkOutput($sformatf("step%0d edit_field", i), 32'(bus.edit_field), 32'(steps[i].expField));
      checkOutput($sformatf("step%0d digits", i), 32'(loadDigits()), 32'(steps[i].expDigits));
    end
    checkOutput("table load pulses", 32'(loadPulses), 32'd5);

    // Bounce: no event while chattering, exactly one after settling.
    setCur(16'h1234);
    applyStimulus(BTN_CTR);
    applyStimulus(BTN_RIGHT);
    checkOutput("bounce field", 32'(bus.edit_field), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.btn_up = 1'b1;
      repeat (2) @(negedge clk);
      bus.btn_up = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checkOutput("bounce no event", 32'(loadDigits()), 32'h1234);
    bus.btn_up = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("bounce one increment", 32'(loadDigits()), 32'h1235);
    applyStimulus(BTN_CTR);
    checkOutput("bounce load pulses", 32'(loadPulses), 32'd6);

    // Auto-repeat: press action 7 edges after the raw edge, repeats at +20 then every 8.
    setCur(16'h1050);
    applyStimulus(BTN_CTR);
    applyStimulus(BTN_RIGHT);
    bus.btn_up = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("latency before action", 32'(loadDigits()), 32'h1050);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency press action", 32'(loadDigits()), 32'h1051);
    repeat (23) @(posedge clk);
    @(negedge clk);
    checkOutput("repeat first", 32'(loadDigits()), 32'h1052);
    repeat (26) @(posedge clk);
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("repeat total", 32'(loadDigits()), 32'h1056);
    applyStimulus(BTN_CTR);
    checkOutput("repeat commit editing", 32'(bus.editing), 32'd0);
    checkOutput("repeat load pulses", 32'(loadPulses), 32'd7);

    // Simultaneous buttons.
    setCur(16'h0815);
    applyStimulus(BTN_CTR);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("up+down ignored", 32'(loadDigits()), 32'h0815);
    checkOutput("up+down still editing", 32'(bus.editing), 32'd1);
    bus.btn_ctr = 1'b1;
    bus.btn_up  = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.btn_ctr = 1'b0;
    bus.btn_up  = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("ctr+up commits", 32'(bus.editing), 32'd0);
    checkOutput("ctr+up unadjusted", 32'(loadDigits()), 32'h0815);
    checkOutput("ctr+up load pulses", 32'(loadPulses), 32'd8);

    // Blink in EDIT_H: capture lands 7 edges after the raw ctr edge.
    setCur(16'h1111);
    bus.btn_ctr = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus.btn_ctr = 1'b0;
    checkOutput("blink capture editing", 32'(bus.editing), 32'd1);
    for (int k = 0; k < 32; k++) begin
      expBlank = ((k / 8) % 2 == 1) ? 4'b1100 : 4'b0000;
      checkOutput($sformatf("blink hours k%0d", k), 32'(bus.blank), 32'(expBlank));
      @(negedge clk);
    end
    bus.btn_right = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkOutput("blink toggle field", 32'(bus.edit_field), 32'd1);
    checkOutput("blink minutes visible", 32'(bus.blank), 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("blink minutes blank", 32'(bus.blank), 32'b0011);
    bus.btn_right = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-edit: outputs clear at once, no load, back in RUN.
    savedLoads = loadPulses;
    #2 btnReset = 1'b0;
    #1 checkAllZero("mid-edit reset");
    repeat (3) @(negedge clk);
    btnReset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("after reset editing", 32'(bus.editing), 32'd0);
    checkOutput("after reset field", 32'(bus.edit_field), 32'd0);
    checkOutput("after reset no load", 32'(loadPulses), 32'(savedLoads));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_set_input.md
Name: time_set_input

Overview:
- User-input front end for the 24-hour clock. Complements the seven-segment output path.
- Conditions the five raw push-buttons: 2-flop synchroniser, debounce, rising-edge detect, auto-repeat on up/down.
- Runs an edit FSM that snapshots the displayed time, lets the user adjust hours and minutes, then emits a one-cycle BCD load to the counter chain.
- Drives a per-digit blank mask so the display driver blinks the field being edited.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised button must differ from its stable value before the stable value flips.
- REPEAT_DELAY, 50000000, cycles up/down must stay held after the press event before the first repeat.
- REPEAT_PERIOD, 15000000, cycles between subsequent repeats while held.
- BLINK_CYCLES, 25000000, half-period of the edit-field blink.

Ports:
- clk  in  1  system clock.
- btn_reset  in  1  asynchronous, active-low reset.
- btn_up, btn_down, btn_ctr, btn_left, btn_right  in  1 each  raw asynchronous buttons, active-high.
- cur_min_ones, cur_min_tens, cur_hour_ones, cur_hour_tens  in  4 each  current BCD time from the counters.
- editing  out  1  high while in an edit state.
- edit_field  out  1  0 = hours, 1 = minutes; valid while editing.
- load  out  1  one-cycle pulse; the counters take the load_* digits.
- load_min_ones, load_min_tens, load_hour_ones, load_hour_tens  out  4 each  BCD edit value. Always reflect the edit registers.
- blank  out  4  per-digit blank: bit0 min_ones, bit1 min_tens, bit2 hour_ones, bit3 hour_tens.

Behaviour:
- Reset (btn_reset low, asynchronous): all flops clear, state RUN, every output 0, edit registers 00:00.
- Conditioning, per button:
  - Two-flop synchroniser, then debounce counter.
  - The counter clears whenever sync equals stable, otherwise increments.
  - When it reaches DEBOUNCE_CYCLES-1, stable takes sync and the counter clears.
  - Press event: one-cycle pulse on the cycle after stable goes 0->1.
  - Release generates no event.
- Auto-repeat, up/down only:
  - While stable stays 1, a hold counter runs from the press event.
  - Extra events fire at REPEAT_DELAY, then every REPEAT_PERIOD after that.
  - The hold counter clears when stable returns to 0.
- Event arbitration, one action per cycle:
  - Priority: ctr > left/right > up/down.
  - left and right in the same cycle both toggle one field, i.e. one toggle.
  - up and down in the same cycle: both ignored.
- FSM states: RUN, EDIT_H, EDIT_M, COMMIT.
  - RUN: ctr event captures the cur_* digits into the edit registers and moves to EDIT_H. All other events are ignored.
  - EDIT_H / EDIT_M: left or right toggles between the two. up/down adjust the field. ctr moves to COMMIT.
  - COMMIT: load = 1 for exactly this cycle, then RUN unconditionally. Events arriving during COMMIT are dropped.
- Arithmetic, BCD modulo:
  - Hours wrap mod 24: 23+1 -> 00, 00-1 -> 23, 09+1 -> 10, 20-1 -> 19.
  - Minutes wrap mod 60: 59+1 -> 00, 00-1 -> 59, 39+1 -> 40.
  - Adjusting one field never changes the other.
  - If the captured digits are not valid BCD for their field, that field is replaced with 00 at capture.
- Outputs:
  - editing = 1 in EDIT_H and EDIT_M; 0 in RUN and COMMIT.
  - edit_field = 1 only in EDIT_M.
- Blink:
  - A free-running phase bit toggles every BLINK_CYCLES. It is forced to 0 (field visible) on entry to EDIT_H/EDIT_M and on every up/down action.
  - blank = 4'b1100 in EDIT_H when phase = 1; 4'b0011 in EDIT_M when phase = 1; 0 otherwise.
- Latency: raw edge held steady -> action register update = 2 + DEBOUNCE_CYCLES + 1 cycles. COMMIT follows the ctr action by 0 cycles (state register update).
- Reset mid-edit: the edit is abandoned, no load pulse is issued, and the design returns to RUN.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, BLINK_CYCLES=8):
- Bounce: btn_up toggles every 2 cycles for 20 cycles, then holds 1 in EDIT_M at 12:34 -> exactly one increment, 12:35; no event during bounce.
- Full edit: cur=23:59; ctr, up, right, up, ctr -> EDIT_H on capture; hours 00; EDIT_M; minutes 00; load pulses 1 cycle with 0,0,0,0; editing falls; state RUN.
- Wrap down: capture 00:00; down in EDIT_H -> 23; right, down -> 23:59; left returns to EDIT_H, minutes unchanged.
- Auto-repeat: hold btn_up 60 cycles past the press event in EDIT_M from 10:50 -> events at press, +20, +28, +36, +44, +52 -> 10:56; release stops repeats.
- Simultaneous: up and down stable-high same cycle -> no change. ctr and up same cycle in EDIT_H -> COMMIT; value unadjusted.
- Reset and blink: blank toggles 4'b1100 / 0000 every 8 cycles in EDIT_H; assert btn_reset mid-edit -> all outputs 0 immediately, load never pulses, RUN after release.
